mannix_mem_arb: RTL

- Parametrised N-client read arbiter for the mannix memory farm.
- Generalises the single `client_priority` scheme into two modes: fixed priority with starvation escape, and round-robin.
- Funnels any number of accelerator read clients (fcc, active, pool, cnn pic/wgt, future units) onto one memory read port.
- Tracks outstanding reads in a tag FIFO so in-order responses route back to the issuing client.

---
 rtl/mannix_mem_arb.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mannix_mem_arb.sv
// mannix_mem_arb: N-client read arbiter for the mannix memory farm.
// Fixed priority with starvation escape or round-robin selection, one
// memory read port, in-order response routing via a tag FIFO.
module mannix_mem_arb #(
    parameter int NUM_CLIENTS     = 5,
    parameter int ADDR_WIDTH      = 19,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 15,
    parameter int IDX_W           = $clog2(NUM_CLIENTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_mode,
    input  logic [IDX_W-1:0]                  cfg_prio_client,
    input  logic [NUM_CLIENTS-1:0]            cl_req,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    output logic [NUM_CLIENTS-1:0]            cl_gnt,
    output logic [NUM_CLIENTS-1:0]            cl_rvalid,
    output logic [DATA_WIDTH-1:0]             cl_rdata,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              busy,
    output logic                              err_unexp_rsp
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ST_ARB,
        ST_ISSUE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        win_id_q, win_id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [7:0]              wait_q [NUM_CLIENTS];
    logic [IDX_W-1:0]        tag_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    err_q;

    logic                    fifo_full, fifo_empty;
    logic                    push, pop;
    logic [IDX_W-1:0]        sel_fixed, sel_rr, win_sel;
    logic [NUM_CLIENTS-1:0]  prio_shift;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign push       = mem_req && mem_gnt;
    assign pop        = mem_rvalid && !fifo_empty;
    // Shifting past the top yields zero, so an out-of-range priority index
    // simply never requests and falls through to lowest-index selection.
    assign prio_shift = cl_req >> cfg_prio_client;

    // Candidate winners for both modes
    always_comb begin
        logic found;
        int unsigned idx;
        sel_fixed = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && cl_req[i] && (wait_q[i] >= 8'(STARVE_LIMIT))) begin
                sel_fixed = IDX_W'(i);
                found     = 1'b1;
            end
        end
        if (!found && prio_shift[0]) begin
            sel_fixed = cfg_prio_client;
            found     = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && cl_req[i]) begin
                sel_fixed = IDX_W'(i);
                found     = 1'b1;
            end
        end
        sel_rr = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_CLIENTS;
            if (!found && cl_req[idx]) begin
                sel_rr = IDX_W'(idx);
                found  = 1'b1;
            end
        end
        win_sel = cfg_mode ? sel_rr : sel_fixed;
    end

    // State, winner and address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARB;
            win_id_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_id_q <= win_id_d;
            addr_q   <= addr_d;
        end
    end

    // Next-state: select in ARB, hold request in ISSUE until accepted
    always_comb begin
        state_d  = state_q;
        win_id_d = win_id_q;
        addr_d   = addr_q;
        case (state_q)
            ST_ARB: begin
                if ((|cl_req) && !fifo_full) begin
                    win_id_d = win_sel;
                    addr_d   = cl_addr[win_sel*ADDR_WIDTH +: ADDR_WIDTH];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Outputs: memory request, grant pulse, response routing, status
    always_comb begin
        mem_req   = (state_q == ST_ISSUE);
        mem_addr  = addr_q;
        cl_gnt    = '0;
        if (mem_req && mem_gnt) begin
            cl_gnt[win_id_q] = 1'b1;
        end
        cl_rvalid = '0;
        if (pop) begin
            cl_rvalid[tag_mem_q[rd_ptr_q]] = 1'b1;
        end
        cl_rdata      = mem_rdata;
        busy          = (state_q == ST_ISSUE) || !fifo_empty;
        err_unexp_rsp = err_q;
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop both apply
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Tag FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= win_id_q;
        end
    end

    // Saturating per-client wait counters and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= IDX_W'(NUM_CLIENTS - 1);
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            if (push) begin
                rr_ptr_q <= win_id_q;
            end
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (!cl_req[i] || cl_gnt[i]) begin
                    wait_q[i] <= '0;
                end else if (!((state_q == ST_ISSUE) && (win_id_q == IDX_W'(i)))
                             && (wait_q[i] != '1)) begin
                    wait_q[i] <= wait_q[i] + 1'b1;
                end
            end
        end
    end

    // Sticky flag for responses arriving with nothing outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (mem_rvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule
